noc_rx_buffer: RTL and testbench

Receive-side buffer between the NoC egress port and the Nios system's 32-bit input PIO. It accepts words from the NoC with a valid/ready handshake and queues them in a small FIFO. It presents one word at a time on a held 32-bit output that the PIO samples. Software releases each word with a four-phase level handshake driven from an output PIO bit.

---
 rtl/noc_rx_buffer_pkg.sv | 19 +
 rtl/noc_rx_buffer_if.sv | 22 ++
 rtl/noc_rx_fifo.sv | 78 +++++++
 rtl/noc_rx_buffer.sv | 123 ++++++++++++
 tb/tb_noc_rx_buffer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_rx_buffer_pkg.sv
// ---------------------------------------------------------------------------
// noc_rx_pkg
// Shared types and default sizes for the NoC receive buffer slice.
//   state_t        : presenter FSM states (IDLE, PRESENT, ACKED)
//   DEFAULT_DATA_W : default word width, equal to the Nios input PIO width
//   DEFAULT_DEPTH  : default FIFO depth (power of two, minimum 2)
// ---------------------------------------------------------------------------
package noc_rx_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACKED   = 2'd2
  } state_t;

endpackage

// File: rtl/noc_rx_buffer_if.sv
// ---------------------------------------------------------------------------
// noc_rx_buffer_if
// Valid/ready word channel from the NoC egress port into the receive buffer.
//   rx_data  : NoC word
//   rx_valid : rx_data is valid (driven by master)
//   rx_ready : receiver can accept a word this cycle (driven by slave)
// Modports: master = NoC side, slave = noc_rx_buffer side.
// ---------------------------------------------------------------------------
interface noc_rx_buffer_if
  import noc_rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/noc_rx_fifo.sv
// ---------------------------------------------------------------------------
// noc_rx_fifo
// Small synchronous FIFO holding NoC words waiting to be presented.
//   clk, reset_n : clock, asynchronous active-low reset (clears everything)
//   push, push_data : write a word (caller guarantees !full)
//   pop          : drop the head word (caller guarantees !empty)
//   head         : current head word
//   count        : occupancy 0..DEPTH
//   full, empty  : decoded from the registered count
// ---------------------------------------------------------------------------
module noc_rx_fifo
  import noc_rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/noc_rx_buffer.sv
// ---------------------------------------------------------------------------
// noc_rx_buffer
// Receive-side buffer between the NoC egress port and a Nios 32-bit input
// PIO. Words are queued in a FIFO and presented one at a time on a held
// output; software releases each word with a four-phase level handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   rx           : valid/ready NoC channel (slave modport)
//   data_out     : presented word (input PIO in_port), held until next load
//   data_avail   : data_out holds an unread word (status PIO bit)
//   cpu_ack      : software acknowledge level (output PIO bit)
//   fill_level   : FIFO occupancy, excluding the presented word
// Optional build macro NOC_RX_ACK_SYNC_EN: cpu_ack passes through a 2-flop
// synchronizer before the FSM (for a cpu_ack from another clock domain).
// ---------------------------------------------------------------------------
module noc_rx_buffer
  import noc_rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  noc_rx_buffer_if.slave         rx,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_avail,
  input  logic                   cpu_ack,
  output logic [$clog2(DEPTH):0] fill_level
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ack_s;
  logic              fifo_pop;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef NOC_RX_ACK_SYNC_EN
  logic ack_meta_q, ack_meta_d;
  logic ack_sync_q, ack_sync_d;

  always_comb begin
    ack_meta_d = cpu_ack;
    ack_sync_d = ack_meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= ack_meta_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign ack_s = ack_sync_q;
`else
  assign ack_s = cpu_ack;
`endif

  // rx_ready comes only from the registered count, never from rx_valid.
  assign rx.rx_ready = !fifo_full;
  assign fifo_push   = rx.rx_valid && !fifo_full;

  noc_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (rx.rx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fill_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    fifo_pop   = 1'b0;
    data_avail = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          data_out_d = fifo_head;
          fifo_pop   = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        data_avail = 1'b1;
        if (ack_s) begin
          state_d = ACKED;
        end
      end
      ACKED: begin
        // Software must drop its ack before the next word is presented.
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_noc_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_noc_rx_buffer
// Directed bench for noc_rx_buffer. Every word handed to the DUT is pushed
// onto a scoreboard queue; a monitor pops and compares whenever data_avail
// rises. Directed checks cover reset values, FIFO fill/stall, ack timing,
// simultaneous push/pop, stuck ack and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_noc_rx_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef NOC_RX_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
`else
  localparam int ACK_LAT = 0;
`endif

  logic              clk;
  logic              reset_n;
  logic [DATA_W-1:0] data_out;
  logic              data_avail;
  logic              cpu_ack;
  logic [2:0]        fill_level;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] sb[$];
  logic              prev_avail = 1'b0;
  logic [DATA_W-1:0] exp_word;

  noc_rx_buffer_if #(.DATA_W(DATA_W)) rx_if ();

  noc_rx_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx_if),
    .data_out   (data_out),
    .data_avail (data_avail),
    .cpu_ack    (cpu_ack),
    .fill_level (fill_level)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: whenever a new word is presented, compare it with the oldest
  // word the stimulus side has queued.
  always @(posedge clk) begin
    #1;
    if (data_avail && !prev_avail) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL present_unexpected: data_out=%h presented, required no presentation", data_out);
      end else begin
        exp_word = sb.pop_front();
        if (data_out !== exp_word) begin
          bad++;
          $display("[TB] FAIL present_order: data_out=%h, required %h", data_out, exp_word);
        end
      end
    end
    prev_avail = data_avail;
  end

  // One directed comparison; counts it and reports on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Push one word over the valid/ready channel; called at a falling edge,
  // returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] word);
    int n = 0;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = word;
    while (!rx_if.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_ready", {31'd0, rx_if.rx_ready}, 32'd1);
    sb.push_back(word);
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  // Full four-phase handshake on the currently presented word; returns with
  // the FSM back in IDLE.
  task automatic ackCycle();
    int n = 0;
    while (!data_avail && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ack_wait_avail", {31'd0, data_avail}, 32'd1);
    cpu_ack = 1'b1;
    repeat (ACK_LAT) @(negedge clk);
    checkOutput("ack_hold_avail", {31'd0, data_avail}, 32'd1);
    @(negedge clk);
    checkOutput("ack_drop_avail", {31'd0, data_avail}, 32'd0);
    cpu_ack = 1'b0;
    repeat (ACK_LAT + 1) @(negedge clk);
  endtask

  // Main directed sequence.
  initial begin
    int n;
    reset_n        = 1'b0;
    cpu_ack        = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_rx_ready", {31'd0, rx_if.rx_ready}, 32'd1);
    checkOutput("reset_data_out", data_out, 32'd0);
    checkOutput("reset_data_avail", {31'd0, data_avail}, 32'd0);
    checkOutput("reset_fill_level", {29'd0, fill_level}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single word: presented one edge after the push, held after ack.
    applyStimulus(32'hDEADBEEF);
    checkOutput("single_avail_before_load", {31'd0, data_avail}, 32'd0);
    @(negedge clk);
    checkOutput("single_avail", {31'd0, data_avail}, 32'd1);
    checkOutput("single_data", data_out, 32'hDEADBEEF);
    ackCycle();
    checkOutput("single_data_held", data_out, 32'hDEADBEEF);
    checkOutput("single_fill_empty", {29'd0, fill_level}, 32'd0);

    // Fill: 0x1 is presented, 0x2..0x5 fill the FIFO, 0x6 stalls.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(i);
    end
    checkOutput("fill_level_full", {29'd0, fill_level}, 32'd4);
    checkOutput("fill_rx_ready", {31'd0, rx_if.rx_ready}, 32'd0);
    checkOutput("fill_data", data_out, 32'h1);
    checkOutput("fill_avail", {31'd0, data_avail}, 32'd1);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 32'h6;
    sb.push_back(32'h6);
    repeat (3) @(negedge clk);
    checkOutput("stall_rx_ready", {31'd0, rx_if.rx_ready}, 32'd0);
    checkOutput("stall_fill", {29'd0, fill_level}, 32'd4);
    ackCycle();
    n = 0;
    while (!rx_if.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_release_ready", {31'd0, rx_if.rx_ready}, 32'd1);
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    checkOutput("stall_push_fill", {29'd0, fill_level}, 32'd4);

    // Order: drain 0x2..0x6 one handshake at a time.
    repeat (5) ackCycle();
    checkOutput("order_fill_zero", {29'd0, fill_level}, 32'd0);
    checkOutput("order_sb_empty", sb.size(), 32'd0);
    checkOutput("order_last_data", data_out, 32'h6);

    // Simultaneous push and pop with two words queued, repeated so the
    // pointers wrap several times.
    applyStimulus(32'h0000_00A0);
    applyStimulus(32'h0000_00B0);
    applyStimulus(32'h0000_00C0);
    checkOutput("simul_start_fill", {29'd0, fill_level}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      ackCycle();
      checkOutput("simul_idle_avail", {31'd0, data_avail}, 32'd0);
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data  = 32'h100 + i;
      sb.push_back(32'h100 + i);
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      checkOutput("simul_fill", {29'd0, fill_level}, 32'd2);
      checkOutput("simul_avail", {31'd0, data_avail}, 32'd1);
    end
    repeat (3) ackCycle();
    checkOutput("simul_drained", {29'd0, fill_level}, 32'd0);

    // Stuck ack: each word drops after one edge; next word waits for ack low.
    cpu_ack = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(32'hA5A5_0001);
    applyStimulus(32'hA5A5_0002);
    checkOutput("stuck_avail", {31'd0, data_avail}, 32'd1);
    checkOutput("stuck_data", data_out, 32'hA5A5_0001);
    @(negedge clk);
    checkOutput("stuck_drop", {31'd0, data_avail}, 32'd0);
    checkOutput("stuck_fill", {29'd0, fill_level}, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("stuck_no_second", {31'd0, data_avail}, 32'd0);
    checkOutput("stuck_data_held", data_out, 32'hA5A5_0001);
    cpu_ack = 1'b0;
    repeat (ACK_LAT + 1) @(negedge clk);
    checkOutput("stuck_release_idle", {31'd0, data_avail}, 32'd0);
    @(negedge clk);
    checkOutput("stuck_second_avail", {31'd0, data_avail}, 32'd1);
    checkOutput("stuck_second_data", data_out, 32'hA5A5_0002);
    ackCycle();

    // Reset mid-stream: everything clears, queued words are discarded.
    applyStimulus(32'h1111_2222);
    applyStimulus(32'h3333_4444);
    checkOutput("midrst_pre_avail", {31'd0, data_avail}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_rx_ready", {31'd0, rx_if.rx_ready}, 32'd1);
    checkOutput("midrst_data_out", data_out, 32'd0);
    checkOutput("midrst_data_avail", {31'd0, data_avail}, 32'd0);
    checkOutput("midrst_fill_level", {29'd0, fill_level}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cpu_ack = 1'b1;
    repeat (4) @(negedge clk);
    cpu_ack = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("postrst_avail", {31'd0, data_avail}, 32'd0);
    checkOutput("postrst_data", data_out, 32'd0);
    checkOutput("postrst_fill", {29'd0, fill_level}, 32'd0);
    applyStimulus(32'h5555_AAAA);
    @(negedge clk);
    checkOutput("postrst_new_data", data_out, 32'h5555_AAAA);
    ackCycle();

    checkOutput("final_sb_empty", sb.size(), 32'd0);
    checkOutput("final_fill", {29'd0, fill_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
